// File: rtl/gry_ptr_sync_cmp.sv
// Read-side consumer of a remote gray write pointer: synchronise, convert to binary, compare to rd_ptr_bin.
// Latency: wptr_bin SYNC_STAGES edges after gry_in is first sampled, occ/aempty one edge later, empty combinational.
// Backpressure: none; status only. Optional sticky pointer check under GRY_PTR_SYNC_CHK_EN.
module gry_ptr_sync_cmp #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gry_in,
    input  logic [WIDTH-1:0] rd_ptr_bin,
    output logic [WIDTH-1:0] wptr_bin,
    output logic [WIDTH-1:0] occ,
    output logic             empty,
    output logic             aempty,
    output logic             err
);

    localparam logic [WIDTH-1:0] AE_TH = WIDTH'(AEMPTY_THRESH);
    localparam logic [WIDTH-1:0] DEPTH = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_last;
    logic [WIDTH-1:0] wptr_nxt;
    logic [WIDTH-1:0] occ_nxt;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Plain flop chain on the asynchronous gray bus; nothing may sit between stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gry_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        wptr_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            wptr_nxt[i] = ^(sync_last >> i);
        end
    end

    // Modulo subtraction handles the wrapped case where wptr_bin < rd_ptr_bin numerically.
    assign occ_nxt = wptr_bin - rd_ptr_bin;

    // Register the converted pointer, the occupancy and the almost-empty flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_bin <= '0;
            occ      <= '0;
            aempty   <= 1'b1;
        end else begin
            wptr_bin <= wptr_nxt;
            occ      <= occ_nxt;
            aempty   <= (occ_nxt <= AE_TH);
        end
    end

    // Combinational so a read that catches up is seen as empty in the same cycle.
    assign empty = (wptr_bin == rd_ptr_bin);

`ifdef GRY_PTR_SYNC_CHK_EN
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] diff;
    logic             multi_bit;
    logic             overrun;

    assign diff      = sync_last ^ prev_q;
    assign multi_bit = ((diff & (diff - 1'b1)) != '0);
    assign overrun   = (occ_nxt > DEPTH);

    // Keep the previous synchronised value and latch any illegal step or overrun until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            err    <= 1'b0;
        end else begin
            prev_q <= sync_last;
            err    <= err | multi_bit | overrun;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gry_ptr_sync_cmp.sv
module tb_gry_ptr_sync_cmp;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] gry_in;
    logic [W-1:0] rd_ptr_bin;
    logic [W-1:0] wptr_bin;
    logic [W-1:0] occ;
    logic         empty;
    logic         aempty;
    logic         err;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef GRY_PTR_SYNC_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    gry_ptr_sync_cmp #(.WIDTH(W), .SYNC_STAGES(2), .AEMPTY_THRESH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .gry_in     (gry_in),
        .rd_ptr_bin (rd_ptr_bin),
        .wptr_bin   (wptr_bin),
        .occ        (occ),
        .empty      (empty),
        .aempty     (aempty),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] gry;
        logic [W-1:0] rd;
        logic [W-1:0] exp_wptr;
        logic [W-1:0] exp_occ;
        logic         exp_empty;
        logic         exp_aempty;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Settled values: gray -> binary by hand, occ = (wptr - rd) mod 16.
        vecs[0]  = '{4'b0000, 4'd0,  4'd0,  4'd0, 1'b1, 1'b1};
        vecs[1]  = '{4'b0001, 4'd0,  4'd1,  4'd1, 1'b0, 1'b1};
        vecs[2]  = '{4'b0011, 4'd0,  4'd2,  4'd2, 1'b0, 1'b1};
        vecs[3]  = '{4'b0010, 4'd0,  4'd3,  4'd3, 1'b0, 1'b0};
        vecs[4]  = '{4'b0010, 4'd12, 4'd3,  4'd7, 1'b0, 1'b0};
        vecs[5]  = '{4'b1100, 4'd0,  4'd8,  4'd8, 1'b0, 1'b0};
        vecs[6]  = '{4'b0111, 4'd5,  4'd5,  4'd0, 1'b1, 1'b1};
        vecs[7]  = '{4'b0111, 4'd4,  4'd5,  4'd1, 1'b0, 1'b1};
        vecs[8]  = '{4'b1000, 4'd14, 4'd15, 4'd1, 1'b0, 1'b1};
        vecs[9]  = '{4'b0000, 4'd14, 4'd0,  4'd2, 1'b0, 1'b1};
        vecs[10] = '{4'b1010, 4'd9,  4'd12, 4'd3, 1'b0, 1'b0};

        // Reset held with a nonzero remote pointer.
        rst = 1'b1; gry_in = 4'b0110; rd_ptr_bin = 4'd0;
        #2;
        tick(2);
        chk("rst_wptr",   wptr_bin, 4'd0);
        chk("rst_occ",    occ,      4'd0);
        chk("rst_empty",  empty,    1'b1);
        chk("rst_aempty", aempty,   1'b1);
        chk("rst_err",    err,      1'b0);
        rst = 1'b0;
        tick(1);
        chk("rel_wptr_e1", wptr_bin, 4'd0);
        tick(1);
        chk("rel_wptr_e2", wptr_bin, 4'd0);
        tick(1);
        chk("rel_wptr_e3", wptr_bin, 4'b0100);

        // Table of settled vectors.
        for (int v = 0; v < 11; v++) begin
            gry_in = vecs[v].gry; rd_ptr_bin = vecs[v].rd;
            tick(4);
            chk($sformatf("vec%0d_wptr", v),   wptr_bin, vecs[v].exp_wptr);
            chk($sformatf("vec%0d_occ", v),    occ,      vecs[v].exp_occ);
            chk($sformatf("vec%0d_empty", v),  empty,    vecs[v].exp_empty);
            chk($sformatf("vec%0d_aempty", v), aempty,   vecs[v].exp_aempty);
        end

        // Read catch-up: empty reacts combinationally, occ one edge later.
        gry_in = 4'b0111; rd_ptr_bin = 4'd4;
        tick(4);
        chk("cu_pre_empty", empty, 1'b0);
        chk("cu_pre_occ",   occ,   4'd1);
        rd_ptr_bin = 4'd5;
        #1;
        chk("cu_empty_now", empty, 1'b1);
        chk("cu_occ_hold",  occ,   4'd1);
        tick(1);
        chk("cu_occ",    occ,    4'd0);
        chk("cu_aempty", aempty, 1'b1);

        // Mid-operation reset clears state immediately.
        gry_in = 4'b1100; rd_ptr_bin = 4'd0;
        tick(4);
        rst = 1'b1; gry_in = 4'b0000;
        #1;
        chk("mrst_wptr",   wptr_bin, 4'd0);
        chk("mrst_occ",    occ,      4'd0);
        chk("mrst_aempty", aempty,   1'b1);
        chk("mrst_empty",  empty,    1'b1);
        chk("mrst_err",    err,      1'b0);
        tick(2);
        rst = 1'b0;
        tick(3);

        // Single write latency.
        gry_in = 4'b0001;
        tick(1);
        chk("sw_wptr_k",  wptr_bin, 4'd0);
        tick(1);
        chk("sw_wptr_k1", wptr_bin, 4'd0);
        chk("sw_empty_k1", empty,   1'b1);
        tick(1);
        chk("sw_wptr_k2",  wptr_bin, 4'd1);
        chk("sw_empty_k2", empty,    1'b0);
        chk("sw_occ_k2",   occ,      4'd0);
        tick(1);
        chk("sw_occ_k3",    occ,    4'd1);
        chk("sw_aempty_k3", aempty, 1'b1);

        // Full depth via legal single-bit gray steps.
        gry_in = 4'b0011; tick(1);
        gry_in = 4'b0010; tick(1);
        gry_in = 4'b0110; tick(1);
        gry_in = 4'b0111; tick(1);
        gry_in = 4'b0101; tick(1);
        gry_in = 4'b0100; tick(1);
        gry_in = 4'b1100; tick(4);
        chk("fd_wptr",   wptr_bin, 4'd8);
        chk("fd_occ",    occ,      4'd8);
        chk("fd_empty",  empty,    1'b0);
        chk("fd_aempty", aempty,   1'b0);
        chk("fd_err",    err,      1'b0);

        // Two-bit gray jump sets the sticky error when the check is built in.
        rst = 1'b1; gry_in = 4'b0000; rd_ptr_bin = 4'd0;
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("ej_err_pre", err, 1'b0);
        gry_in = 4'b0011;
        tick(2);
        chk("ej_err_k1", err, 1'b0);
        tick(1);
        chk("ej_err_k2", err, ERR_EXP);
        tick(5);
        chk("ej_err_sticky", err, ERR_EXP);
        chk("ej_wptr", wptr_bin, 4'd2);
        rst = 1'b1;
        #1;
        chk("ej_err_rst", err, 1'b0);
        tick(1);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
